// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_WORD_DEPTH = 16;
  localparam int DEF_WORD_WIDTH = 8;

  // SRAM write-enable polarity: low writes, high reads.
  localparam logic SRAM_WE_WRITE = 1'b0;
  localparam logic SRAM_WE_READ  = 1'b1;

  // Operation granted on the single SRAM port this cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } fifo_op_e;
endpackage

// File: rtl/sram_fifo_ptr.sv
// Read/write pointers, occupancy count and registered full/empty flags.
module sram_fifo_ptr
  import sram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  fifo_op_e              op_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;

  // Explicit wrap so a non-power-of-two depth still cycles without gaps.
  function automatic logic [ADDR_WIDTH-1:0] nxt(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Next-state: push and pop are mutually exclusive, so count moves by one.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op_i)
      OP_PUSH: begin
        wr_ptr_d = nxt(wr_ptr_q);
        count_d  = count_q + 1'b1;
      end
      OP_POP: begin
        rd_ptr_d = nxt(rd_ptr_q);
        count_d  = count_q - 1'b1;
      end
      default: ;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving an external single-port SRAM with registered read
// data. Pop has priority on the shared port; a pushing producer is stalled.
// Optional sticky overflow/underflow flags: define SRAM_FIFO_ERR_FLAGS_EN.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [WORD_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_req,
  output logic                  pop_valid,
  output logic [WORD_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  output logic                  sram_we,
  input  logic [WORD_WIDTH-1:0] sram_dout
`ifdef SRAM_FIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  pop_acc, push_acc;
  logic                  pop_valid_q, pop_valid_d;
  logic [WORD_WIDTH-1:0] din_q, din_d;
  fifo_op_e              op;

  // Grant: reset blocks everything so the SRAM never sees a write during rst.
  always_comb begin
    pop_acc    = !rst && pop_req && !empty;
    push_ready = !rst && !full && !(pop_req && !empty);
    push_acc   = push_valid && push_ready;
    op         = OP_IDLE;
    if (pop_acc)       op = OP_POP;
    else if (push_acc) op = OP_PUSH;
  end

  // SRAM port: idle cycles park on a read of rd_ptr and hold the write data.
  always_comb begin
    sram_we     = SRAM_WE_READ;
    sram_addr   = rd_ptr;
    din_d       = din_q;
    if (op == OP_PUSH) begin
      sram_we   = SRAM_WE_WRITE;
      sram_addr = wr_ptr;
      din_d     = push_data;
    end
    sram_din    = din_d;
    pop_valid_d = (op == OP_POP);
  end

  // Read-valid tracking and held write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_valid_q <= 1'b0;
      din_q       <= '0;
    end else begin
      pop_valid_q <= pop_valid_d;
      din_q       <= din_d;
    end
  end

  // SRAM output is already registered, so it is forwarded in the valid cycle.
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_valid_q ? sram_dout : '0;

  sram_fifo_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_DEPTH(WORD_DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .op_i    (op),
    .wr_ptr_o(wr_ptr),
    .rd_ptr_o(rd_ptr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef SRAM_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (push_valid && full);
      udf_q <= udf_q | (pop_req && empty);
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural single-port SRAM.
module tb_sram_fifo_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid, pop_req;
  logic [WW-1:0] push_data;
  logic          push_ready, pop_valid, full, empty, sram_we;
  logic [WW-1:0] pop_data, sram_din, sram_dout;
  logic [AW:0]   count;
  logic [AW-1:0] sram_addr;
`ifdef SRAM_FIFO_ERR_FLAGS_EN
  logic          ovf_err, udf_err;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [WW-1:0] m_q[$];   // model FIFO contents
  logic [WW-1:0] exp_q[$]; // scoreboard of words due on pop_data
  bit exp_pv = 0, exp_ready = 0, exp_we = 1, chk_en = 0, mon_en = 0;
  logic [WW-1:0] exp_din;

  sram_fifo_ctrl #(.ADDR_WIDTH(AW), .WORD_DEPTH(DEPTH), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .full(full), .empty(empty), .count(count),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
    .sram_dout(sram_dout)
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_we == 1'b0) mem[sram_addr] <= sram_din;
    else sram_dout <= mem[sram_addr];
  end

  // Monitor: compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (pop_valid !== exp_pv) begin
        n_bad++; $display("FAIL pop_valid: got %b want %b", pop_valid, exp_pv);
      end
      if (exp_pv && exp_q.size() > 0) begin
        logic [WW-1:0] d;
        d = exp_q.pop_front();
        n_vec++;
        if (pop_data !== d) begin
          n_bad++; $display("FAIL pop_data: got %h want %h", pop_data, d);
        end
      end
      if (chk_en) begin
        n_vec++;
        if (push_ready !== exp_ready) begin
          n_bad++; $display("FAIL push_ready: got %b want %b", push_ready, exp_ready);
        end
        n_vec++;
        if (sram_we !== exp_we) begin
          n_bad++; $display("FAIL sram_we: got %b want %b", sram_we, exp_we);
        end
        if (!exp_we) begin
          n_vec++;
          if (sram_din !== exp_din) begin
            n_bad++; $display("FAIL sram_din: got %h want %h", sram_din, exp_din);
          end
        end
      end
    end
  end

  // One clock of stimulus; expectations come from the model queue only.
  task automatic drive(input bit pv, input logic [WW-1:0] pd, input bit pr);
    bit ap, aw;
    push_valid = pv; push_data = pd; pop_req = pr;
    ap = pr && (m_q.size() != 0);
    aw = pv && (m_q.size() < DEPTH) && !ap;
    exp_ready = (m_q.size() < DEPTH) && !ap;
    exp_we = !aw;
    exp_din = pd;
    chk_en = 1;
    @(posedge clk);
    chk_en = 0;
    if (aw) m_q.push_back(pd);
    if (ap) exp_q.push_back(m_q.pop_front());
    exp_pv = ap;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; push_valid = 1; push_data = 8'h5A; pop_req = 0;
    #2;
    n_vec++; if (count !== 0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if (empty !== 1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_vec++; if (full !== 0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_vec++; if (pop_valid !== 0) begin n_bad++; $display("FAIL reset_pop_valid: got %b want 0", pop_valid); end
    n_vec++; if (pop_data !== 0) begin n_bad++; $display("FAIL reset_pop_data: got %h want 0", pop_data); end
    n_vec++; if (sram_we !== 1) begin n_bad++; $display("FAIL reset_sram_we: got %b want 1", sram_we); end
    @(posedge clk); #1;
    rst = 0; push_valid = 0; pop_req = 0;
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    n_vec++; if (ovf_err !== 0 || udf_err !== 0) begin
      n_bad++; $display("FAIL reset_err: got %b%b want 00", ovf_err, udf_err);
    end
`endif
    mon_en = 1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) drive(1, 8'h10 + 8'(i % 16), 0);
    n_vec++; if (full !== 1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
    n_vec++; if (count !== 16) begin n_bad++; $display("FAIL fill_count: got %0d want 16", count); end
    n_vec++; if (push_ready !== 0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", push_ready); end
    drive(1, 8'h99, 0); // dropped
    n_vec++; if (count !== 16) begin n_bad++; $display("FAIL fill_drop_count: got %0d want 16", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(0, 8'h00, 1);
    drive(0, 8'h00, 1); // pop on empty, ignored
    drive(0, 8'h00, 0);
    n_vec++; if (empty !== 1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    n_vec++; if (count !== 0) begin n_bad++; $display("FAIL drain_count: got %0d want 0", count); end
  endtask

  task automatic test_err_flags();
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    n_vec++; if (ovf_err !== 1) begin n_bad++; $display("FAIL ovf_err: got %b want 1", ovf_err); end
    n_vec++; if (udf_err !== 1) begin n_bad++; $display("FAIL udf_err: got %b want 1", udf_err); end
`endif
  endtask

  task automatic test_push_pop_collide();
    drive(1, 8'h21, 0); drive(1, 8'h22, 0); drive(1, 8'h23, 0);
    drive(1, 8'hAA, 1); // pop wins the port
    n_vec++; if (count !== 2) begin n_bad++; $display("FAIL collide_count: got %0d want 2", count); end
    drive(1, 8'hAA, 0);
    n_vec++; if (count !== 3) begin n_bad++; $display("FAIL collide_retry_count: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'h40 + 8'(i), 0);
      if (i % 2 == 1) drive(0, 8'h00, 1);
    end
    n_vec++; if (count !== 10) begin n_bad++; $display("FAIL wrap_count: got %0d want 10", count); end
    for (int i = 0; i < 10; i++) drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    n_vec++; if (empty !== 1) begin n_bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid_read();
    drive(1, 8'h61, 0); drive(1, 8'h62, 0);
    mon_en = 0;
    push_valid = 0; pop_req = 1;
    #2 rst = 1;
    #1;
    n_vec++; if (count !== 0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_vec++; if (empty !== 1) begin n_bad++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    @(posedge clk); #1;
    n_vec++; if (pop_valid !== 0) begin n_bad++; $display("FAIL rstmid_pop_valid: got %b want 0", pop_valid); end
    rst = 0; pop_req = 0;
    m_q.delete(); exp_q.delete(); exp_pv = 0;
    mon_en = 1;
    drive(0, 8'h00, 1); // pop right after reset: FIFO is empty
    drive(0, 8'h00, 0);
    n_vec++; if (empty !== 1) begin n_bad++; $display("FAIL rstmid_post_empty: got %b want 1", empty); end
`ifdef SRAM_FIFO_ERR_FLAGS_EN
    n_vec++; if (ovf_err !== 0) begin n_bad++; $display("FAIL rstmid_ovf: got %b want 0", ovf_err); end
`endif
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_err_flags();
        test_push_pop_collide();
        test_wrap();
        test_reset_mid_read();
      end
      begin
        #50000;
        n_bad++;
        $display("FAIL timeout: got no completion want completion");
      end
    join_any
    disable fork;
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
